// File: rtl/traffic_light_monitor_if.sv
// Signal bundle between a traffic-light controller and traffic_light_monitor.
// fault_count exists only when TRAFFIC_MON_FAULT_COUNT_EN is defined.
interface traffic_light_monitor_if;
    logic [2:0] light_A;
    logic [2:0] light_B;
    logic       clear;
    logic [2:0] lamp_A;
    logic [2:0] lamp_B;
    logic       fault;
    logic [2:0] fault_code;
`ifdef TRAFFIC_MON_FAULT_COUNT_EN
    logic [7:0] fault_count;
`endif

`ifdef TRAFFIC_MON_FAULT_COUNT_EN
    modport master (
        output light_A, light_B, clear,
        input  lamp_A, lamp_B, fault, fault_code, fault_count
    );
    modport slave (
        input  light_A, light_B, clear,
        output lamp_A, lamp_B, fault, fault_code, fault_count
    );
`else
    modport master (
        output light_A, light_B, clear,
        input  lamp_A, lamp_B, fault, fault_code
    );
    modport slave (
        input  light_A, light_B, clear,
        output lamp_A, lamp_B, fault, fault_code
    );
`endif
endinterface

// File: rtl/traffic_light_monitor.sv
// Safety monitor between a two-direction traffic-light controller and the lamps.
// Optional entry counter output enabled by macro TRAFFIC_MON_FAULT_COUNT_EN.
module traffic_light_monitor #(
    parameter int YEL_MAX    = 5,
    parameter int FLASH_HALF = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    traffic_light_monitor_if.slave  mon
);

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    localparam logic [3:0] YEL_MAX_C    = 4'(YEL_MAX);
    localparam logic [4:0] FLASH_HALF_C = 5'(FLASH_HALF);

    localparam logic [2:0] CODE_NONE     = 3'd0;
    localparam logic [2:0] CODE_ILLEGAL  = 3'd1;
    localparam logic [2:0] CODE_CONFLICT = 3'd2;
    localparam logic [2:0] CODE_SEQUENCE = 3'd3;
    localparam logic [2:0] CODE_OVERRUN  = 3'd4;

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_FAULT  = 1'b1
    } state_e;

    function automatic logic is_one_hot(input logic [2:0] code);
        logic ok;
        case (code)
            LAMP_RED: ok = 1'b1;
            LAMP_YEL: ok = 1'b1;
            LAMP_GRN: ok = 1'b1;
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Holding is always legal; otherwise only R->G, G->Y, Y->R.
    function automatic logic is_legal_step(input logic [2:0] prev, input logic [2:0] cur);
        logic ok;
        if (prev == cur) begin
            ok = 1'b1;
        end else begin
            case (prev)
                LAMP_RED: ok = (cur == LAMP_GRN);
                LAMP_GRN: ok = (cur == LAMP_YEL);
                LAMP_YEL: ok = (cur == LAMP_RED);
                default:  ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    function automatic logic [3:0] yel_next(input logic [2:0] cur, input logic [3:0] cnt);
        logic [3:0] nxt;
        if (cur != LAMP_YEL) begin
            nxt = 4'd0;
        end else if (cnt == 4'd15) begin
            nxt = 4'd15;
        end else begin
            nxt = cnt + 4'd1;
        end
        return nxt;
    endfunction

    state_e     state_q,     state_d;
    logic [2:0] prev_a_q,    prev_a_d;
    logic [2:0] prev_b_q,    prev_b_d;
    logic [3:0] yel_a_q,     yel_a_d;
    logic [3:0] yel_b_q,     yel_b_d;
    logic       flash_q,     flash_d;
    logic [3:0] flash_cnt_q, flash_cnt_d;
    logic [2:0] lamp_a_q,    lamp_a_d;
    logic [2:0] lamp_b_q,    lamp_b_d;
    logic       fault_q,     fault_d;
    logic [2:0] code_q,      code_d;
`ifdef TRAFFIC_MON_FAULT_COUNT_EN
    logic [7:0] fault_count_q, fault_count_d;
`endif

    logic [3:0] yel_a_s;
    logic [3:0] yel_b_s;
    logic [2:0] viol_code_s;
    logic       both_red_s;
    logic [4:0] flash_cnt_inc_s;

    // Violation classification on the current inputs, first match wins.
    always_comb begin
        yel_a_s     = yel_next(mon.light_A, yel_a_q);
        yel_b_s     = yel_next(mon.light_B, yel_b_q);
        viol_code_s = CODE_NONE;
        if (!is_one_hot(mon.light_A) || !is_one_hot(mon.light_B)) begin
            viol_code_s = CODE_ILLEGAL;
        end else if ((mon.light_A != LAMP_RED) && (mon.light_B != LAMP_RED)) begin
            viol_code_s = CODE_CONFLICT;
        end else if (!is_legal_step(prev_a_q, mon.light_A) ||
                     !is_legal_step(prev_b_q, mon.light_B)) begin
            viol_code_s = CODE_SEQUENCE;
        end else if ((yel_a_s > YEL_MAX_C) || (yel_b_s > YEL_MAX_C)) begin
            viol_code_s = CODE_OVERRUN;
        end else begin
            viol_code_s = CODE_NONE;
        end
    end

    // Next-state and registered-output computation for NORMAL/FAULT.
    always_comb begin
        state_d         = state_q;
        prev_a_d        = mon.light_A;
        prev_b_d        = mon.light_B;
        yel_a_d         = yel_a_q;
        yel_b_d         = yel_b_q;
        flash_d         = flash_q;
        flash_cnt_d     = flash_cnt_q;
        lamp_a_d        = lamp_a_q;
        lamp_b_d        = lamp_b_q;
        fault_d         = fault_q;
        code_d          = code_q;
        both_red_s      = (mon.light_A == LAMP_RED) && (mon.light_B == LAMP_RED);
        flash_cnt_inc_s = {1'b0, flash_cnt_q} + 5'd1;
`ifdef TRAFFIC_MON_FAULT_COUNT_EN
        fault_count_d   = fault_count_q;
`endif
        case (state_q)
            ST_NORMAL: begin
                if (viol_code_s != CODE_NONE) begin
                    // The entry edge already drives the first flash phase.
                    state_d     = ST_FAULT;
                    fault_d     = 1'b1;
                    code_d      = viol_code_s;
                    flash_d     = 1'b1;
                    flash_cnt_d = 4'd0;
                    lamp_a_d    = LAMP_RED;
                    lamp_b_d    = LAMP_RED;
                    yel_a_d     = 4'd0;
                    yel_b_d     = 4'd0;
`ifdef TRAFFIC_MON_FAULT_COUNT_EN
                    if (fault_count_q != 8'hFF) begin
                        fault_count_d = fault_count_q + 8'd1;
                    end else begin
                        fault_count_d = fault_count_q;
                    end
`endif
                end else begin
                    lamp_a_d = mon.light_A;
                    lamp_b_d = mon.light_B;
                    yel_a_d  = yel_a_s;
                    yel_b_d  = yel_b_s;
                end
            end
            ST_FAULT: begin
                if (mon.clear && both_red_s) begin
                    state_d     = ST_NORMAL;
                    fault_d     = 1'b0;
                    code_d      = CODE_NONE;
                    flash_d     = 1'b0;
                    flash_cnt_d = 4'd0;
                    lamp_a_d    = LAMP_RED;
                    lamp_b_d    = LAMP_RED;
                    yel_a_d     = 4'd0;
                    yel_b_d     = 4'd0;
                end else begin
                    if (flash_cnt_inc_s >= FLASH_HALF_C) begin
                        flash_d     = ~flash_q;
                        flash_cnt_d = 4'd0;
                    end else begin
                        flash_d     = flash_q;
                        flash_cnt_d = flash_cnt_inc_s[3:0];
                    end
                    lamp_a_d = {flash_d, 2'b00};
                    lamp_b_d = {flash_d, 2'b00};
                    yel_a_d  = 4'd0;
                    yel_b_d  = 4'd0;
                end
            end
            default: begin
                state_d     = ST_FAULT;
                fault_d     = 1'b1;
                code_d      = CODE_ILLEGAL;
                flash_d     = 1'b1;
                flash_cnt_d = 4'd0;
                lamp_a_d    = LAMP_RED;
                lamp_b_d    = LAMP_RED;
                yel_a_d     = 4'd0;
                yel_b_d     = 4'd0;
            end
        endcase
    end

    // State and output registers with asynchronous reset to the all-red safe state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_NORMAL;
            prev_a_q      <= LAMP_RED;
            prev_b_q      <= LAMP_RED;
            yel_a_q       <= 4'd0;
            yel_b_q       <= 4'd0;
            flash_q       <= 1'b0;
            flash_cnt_q   <= 4'd0;
            lamp_a_q      <= LAMP_RED;
            lamp_b_q      <= LAMP_RED;
            fault_q       <= 1'b0;
            code_q        <= CODE_NONE;
`ifdef TRAFFIC_MON_FAULT_COUNT_EN
            fault_count_q <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            prev_a_q      <= prev_a_d;
            prev_b_q      <= prev_b_d;
            yel_a_q       <= yel_a_d;
            yel_b_q       <= yel_b_d;
            flash_q       <= flash_d;
            flash_cnt_q   <= flash_cnt_d;
            lamp_a_q      <= lamp_a_d;
            lamp_b_q      <= lamp_b_d;
            fault_q       <= fault_d;
            code_q        <= code_d;
`ifdef TRAFFIC_MON_FAULT_COUNT_EN
            fault_count_q <= fault_count_d;
`endif
        end
    end

    assign mon.lamp_A     = lamp_a_q;
    assign mon.lamp_B     = lamp_b_q;
    assign mon.fault      = fault_q;
    assign mon.fault_code = code_q;
`ifdef TRAFFIC_MON_FAULT_COUNT_EN
    assign mon.fault_count = fault_count_q;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed-vector bench for traffic_light_monitor (YEL_MAX=5, FLASH_HALF=1).
// Counter checks are compiled in when TRAFFIC_MON_FAULT_COUNT_EN is defined.
module tb_traffic_light_monitor;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    traffic_light_monitor_if tlm_if ();

    traffic_light_monitor #(
        .YEL_MAX    (5),
        .FLASH_HALF (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mon   (tlm_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run = tests_run + 1;
        if (obs !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [2:0] a, input logic [2:0] b, input logic clr);
        tlm_if.light_A = a;
        tlm_if.light_B = b;
        tlm_if.clear   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [2:0] la, input logic [2:0] lb,
                             input logic f, input logic [2:0] code);
        check_val({tag, "_lampA"}, 8'(tlm_if.lamp_A), 8'(la));
        check_val({tag, "_lampB"}, 8'(tlm_if.lamp_B), 8'(lb));
        check_val({tag, "_fault"}, 8'(tlm_if.fault), 8'(f));
        check_val({tag, "_code"},  8'(tlm_if.fault_code), 8'(code));
    endtask

    logic [2:0] seq_a [8];
    logic [2:0] seq_b [8];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        seq_a = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
        seq_b = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

        reset          = 1'b1;
        tlm_if.light_A = 3'b100;
        tlm_if.light_B = 3'b100;
        tlm_if.clear   = 1'b0;
        #1;
        check_out("reset", 3'b100, 3'b100, 1'b0, 3'd0);
`ifdef TRAFFIC_MON_FAULT_COUNT_EN
        check_val("reset_count", tlm_if.fault_count, 8'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Legal cycle: lamps mirror inputs one cycle later.
        for (int i = 0; i < 8; i++) begin
            step(seq_a[i], seq_b[i], 1'b0);
            check_out($sformatf("legal%0d", i), seq_a[i], seq_b[i], 1'b0, 3'd0);
        end

        // Conflict and flash pattern.
        step(3'b001, 3'b001, 1'b0);
        check_out("conflict", 3'b100, 3'b100, 1'b1, 3'd2);
        step(3'b001, 3'b001, 1'b0);
        check_out("flash0", 3'b000, 3'b000, 1'b1, 3'd2);
        step(3'b010, 3'b000, 1'b0);
        check_out("flash1", 3'b100, 3'b100, 1'b1, 3'd2);
        step(3'b001, 3'b001, 1'b0);
        check_out("flash2", 3'b000, 3'b000, 1'b1, 3'd2);
        step(3'b100, 3'b100, 1'b1);
        check_out("exit1", 3'b100, 3'b100, 1'b0, 3'd0);

        // Violation with clear in the same cycle: the violation wins.
        step(3'b001, 3'b001, 1'b1);
        check_out("viol_clr", 3'b100, 3'b100, 1'b1, 3'd2);
        step(3'b100, 3'b100, 1'b1);
        check_out("exit2", 3'b100, 3'b100, 1'b0, 3'd0);

        // Bad sequence, ignored clear, proper clear.
        step(3'b001, 3'b100, 1'b0);
        check_out("seq_g", 3'b001, 3'b100, 1'b0, 3'd0);
        step(3'b100, 3'b100, 1'b0);
        check_out("bad_seq", 3'b100, 3'b100, 1'b1, 3'd3);
        step(3'b100, 3'b001, 1'b1);
        check_val("clr_ignored_fault", 8'(tlm_if.fault), 8'd1);
        check_val("clr_ignored_code", 8'(tlm_if.fault_code), 8'd3);
        step(3'b100, 3'b100, 1'b1);
        check_out("exit3", 3'b100, 3'b100, 1'b0, 3'd0);

        // Yellow overrun after six consecutive yellow cycles.
        step(3'b001, 3'b100, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(3'b010, 3'b100, 1'b0);
            if (i < 5) begin
                check_out($sformatf("yel%0d", i), 3'b010, 3'b100, 1'b0, 3'd0);
            end else begin
                check_out("yel_overrun", 3'b100, 3'b100, 1'b1, 3'd4);
            end
        end
        step(3'b100, 3'b100, 1'b1);
        step(3'b011, 3'b100, 1'b0);
        check_out("illegal_011", 3'b100, 3'b100, 1'b1, 3'd1);
        step(3'b100, 3'b100, 1'b1);
        step(3'b000, 3'b100, 1'b0);
        check_out("illegal_000", 3'b100, 3'b100, 1'b1, 3'd1);
        step(3'b100, 3'b100, 1'b1);
        check_out("exit4", 3'b100, 3'b100, 1'b0, 3'd0);

        // Asynchronous reset in the middle of FAULT.
        step(3'b001, 3'b001, 1'b0);
        check_val("pre_rst_fault", 8'(tlm_if.fault), 8'd1);
        step(3'b001, 3'b001, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_out("async_rst", 3'b100, 3'b100, 1'b0, 3'd0);
`ifdef TRAFFIC_MON_FAULT_COUNT_EN
        check_val("async_rst_count", tlm_if.fault_count, 8'd0);
`endif
        #3;
        reset = 1'b0;
        step(3'b001, 3'b100, 1'b0);
        check_out("post_rst_rg", 3'b001, 3'b100, 1'b0, 3'd0);

        // Three fault entries for the optional counter.
        step(3'b001, 3'b001, 1'b0);
        step(3'b100, 3'b100, 1'b1);
        step(3'b001, 3'b001, 1'b0);
        step(3'b100, 3'b100, 1'b1);
        step(3'b001, 3'b001, 1'b0);
        check_out("third_entry", 3'b100, 3'b100, 1'b1, 3'd2);
`ifdef TRAFFIC_MON_FAULT_COUNT_EN
        check_val("count3", tlm_if.fault_count, 8'd3);
`endif
        step(3'b100, 3'b100, 1'b1);
        check_out("exit5", 3'b100, 3'b100, 1'b0, 3'd0);
`ifdef TRAFFIC_MON_FAULT_COUNT_EN
        check_val("count3_after_clear", tlm_if.fault_count, 8'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter: YEL_MAX, default 5, maximum consecutive cycles either direction may show yellow.
REQ-002 Parameter: FLASH_HALF, default 1, cycles per half-period of the fault flash (1 cycle = 1 s at the system clock).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 light_A  input  3  controller command for direction A; bit2=red, bit1=yellow, bit0=green.
REQ-006 light_B  input  3  controller command for direction B; same encoding.
REQ-007 clear  input  1  operator fault-clear request, sampled per cycle.
REQ-008 lamp_A  output  3  registered lamp drive for direction A, same encoding.
REQ-009 lamp_B  output  3  registered lamp drive for direction B.
REQ-010 fault  output  1  high while the monitor is in FAULT.
REQ-011 fault_code  output  3  cause of the latched fault; 0 when no fault.

Function
REQ-012 Two states, NORMAL and FAULT; the monitor registers prev_A/prev_B, the previous cycle's inputs.
REQ-013 NORMAL: lamp_A/lamp_B follow light_A/light_B with exactly 1 cycle latency.
REQ-014 Checks run every NORMAL cycle on current inputs; first match in priority order sets fault_code:
  - 1 illegal code: either input not one-hot (000, or more than one bit set);
  - 2 conflict: neither input is red (100);
  - 3 bad sequence: a direction changes other than R->G, G->Y, Y->R (holding the same value is legal);
  - 4 yellow overrun: a direction shows yellow for more than YEL_MAX consecutive cycles.
REQ-015 A direction's yellow counter is 4 bits, counts cycles the input is 010, clears when it is not 010, and saturates at 15.
REQ-016 On any detected violation, the next edge enters FAULT, asserts fault, and latches fault_code; that edge's lamps already show the flash pattern, never the violating input.
REQ-017 FAULT: lamp_A = lamp_B = {flash,0,0}; flash starts at 1 on entry and toggles every FLASH_HALF cycles via a 4-bit counter.
REQ-018 FAULT: inputs are ignored for checking; fault_code holds.
REQ-019 FAULT exits to NORMAL when clear=1 and both inputs equal 100 on the same edge: fault=0, fault_code=0, lamps=100/100, yellow counters cleared.
REQ-020 clear with inputs not both red is ignored; clear in NORMAL has no effect.
REQ-021 A violation and a clear in the same cycle: the violation wins.
REQ-022 prev_A/prev_B update every cycle in both states, so sequence checks resume from the inputs present at exit.

Reset
REQ-023 Reset forces state NORMAL, lamp_A=lamp_B=100, fault=0, fault_code=0, prev_A=prev_B=100, yellow and flash counters to 0.
REQ-024 Reset asserted mid-FAULT or mid-yellow takes effect immediately, without waiting for a clock edge.
REQ-025 After reset release, R->G on either direction is legal on the first cycle.

Configuration
REQ-026 With macro TRAFFIC_MON_FAULT_COUNT_EN defined, output fault_count (8 bits) counts entries into FAULT, saturates at 255, resets to 0, and is not cleared by clear.
REQ-027 Without TRAFFIC_MON_FAULT_COUNT_EN, the fault_count port and its logic do not exist; all other behaviour is identical.

Verification
REQ-028 Legal cycle A:G/B:R, A:Y x3, A:R, B:G -> lamps mirror the inputs one cycle later; fault stays 0.
REQ-029 light_A=001 and light_B=001 in the same cycle -> next edge: fault=1, fault_code=2, lamps 100/100, then 000/000 and 100/100 alternating each cycle (FLASH_HALF=1).
REQ-030 light_A 001->100 (skipping yellow) -> fault_code=3; assert clear while light_B=001 -> stays FAULT; clear with both inputs 100 -> NORMAL, fault_code=0.
REQ-031 light_A=010 held 6 cycles (YEL_MAX=5) -> fault_code=4 on the edge after cycle 6; light_A=011 -> fault_code=1; light_A=000 -> fault_code=1.
REQ-032 Assert reset mid-FAULT between clock edges -> outputs go to reset values immediately; with TRAFFIC_MON_FAULT_COUNT_EN defined, three fault entries -> fault_count=3, unchanged by clear.
